// File: rtl/kbd_input_fifo.sv
// kbd_input_fifo: keyboard input stage. It detects new non-zero keystroke codes,
// queues them in a DEPTH-entry FIFO and serves them through two read-only MMIO
// words.
//   DATA_ADDR read : pops the head entry into rd_data (returns 0 when empty)
//   STAT_ADDR read : {47'b0, count[8:0], 6'b0, overflow, key_avail}, clears overflow
// Ports:
//   clk, reset (synchronous, active-low)
//   key_in[63:0]                    raw keystroke code, 0 = no key
//   rd_en, rd_addr[63:0]            core read strobe and address
//   rd_data[63:0], key_avail        registered outputs
// Optional feature: define KBD_DEBOUNCE_EN to accept a code only after two
// consecutive identical samples.
module kbd_input_fifo #(
    parameter int unsigned DEPTH     = 8,
    parameter logic [63:0] DATA_ADDR = 64'h100,
    parameter logic [63:0] STAT_ADDR = 64'h108
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] key_in,
    input  logic        rd_en,
    input  logic [63:0] rd_addr,
    output logic [63:0] rd_data,
    output logic        key_avail
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [63:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic [63:0]   key_samp_q;
    logic [63:0]   rd_data_q, rd_data_d;
    logic          key_avail_q, key_avail_d;

    logic          push_c, pop_c, full_c, wr_c;
    logic          data_rd_c, stat_rd_c;
    logic [63:0]   status_c;

`ifdef KBD_DEBOUNCE_EN
    logic [63:0]   last_stable_q, last_stable_d;
    logic          stable_c;
`endif

    // Keystroke edge detection
    always_comb begin
`ifdef KBD_DEBOUNCE_EN
        // Stable once two consecutive samples agree; last_stable tracks 0 too,
        // so release followed by the same code pushes again.
        stable_c      = (key_in == key_samp_q);
        last_stable_d = stable_c ? key_in : last_stable_q;
        push_c        = stable_c && (key_in != last_stable_q) && (key_in != '0);
`else
        push_c        = (key_in != key_samp_q) && (key_in != '0);
`endif
    end

    // Read decode, FIFO bookkeeping and next read data
    always_comb begin
        data_rd_c   = rd_en && (rd_addr == DATA_ADDR);
        stat_rd_c   = rd_en && (rd_addr == STAT_ADDR);
        full_c      = (count_q == CW'(DEPTH));
        pop_c       = data_rd_c && (count_q != '0);
        // A simultaneous pop frees the slot, so a full FIFO can still accept.
        wr_c        = push_c && (!full_c || pop_c);
        status_c    = {47'b0, 9'(count_q), 6'b0, overflow_q, key_avail_q};

        wr_ptr_d    = wr_c  ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d    = pop_c ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d     = count_q;
        if (wr_c && !pop_c) begin
            count_d = count_q + CW'(1);
        end else if (pop_c && !wr_c) begin
            count_d = count_q - CW'(1);
        end
        key_avail_d = (count_d != '0);

        // Set wins over the status-read clear on the same edge.
        overflow_d  = stat_rd_c ? 1'b0 : overflow_q;
        if (push_c && !wr_c) begin
            overflow_d = 1'b1;
        end

        rd_data_d   = rd_data_q;
        if (rd_en) begin
            if (pop_c) begin
                rd_data_d = mem_q[rd_ptr_q];
            end else if (stat_rd_c) begin
                rd_data_d = status_c;
            end else begin
                rd_data_d = '0;
            end
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            overflow_q    <= 1'b0;
            key_samp_q    <= '0;
            rd_data_q     <= '0;
            key_avail_q   <= 1'b0;
`ifdef KBD_DEBOUNCE_EN
            last_stable_q <= '0;
`endif
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            overflow_q    <= overflow_d;
            key_samp_q    <= key_in;
            rd_data_q     <= rd_data_d;
            key_avail_q   <= key_avail_d;
`ifdef KBD_DEBOUNCE_EN
            last_stable_q <= last_stable_d;
`endif
        end
    end

    // FIFO storage; contents are qualified by the pointers, so no reset needed
    always_ff @(posedge clk) begin
        if (reset && wr_c) begin
            mem_q[wr_ptr_q] <= key_in;
        end
    end

    assign rd_data   = rd_data_q;
    assign key_avail = key_avail_q;

endmodule

// File: tb/tb_kbd_input_fifo.sv
// Directed testbench for kbd_input_fifo (DEPTH=8, default addresses).
module tb_kbd_input_fifo;

    localparam logic [63:0] DATA_A = 64'h100;
    localparam logic [63:0] STAT_A = 64'h108;
    localparam logic [63:0] BAD_A  = 64'h110;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] key_in;
    logic        rd_en;
    logic [63:0] rd_addr;
    logic [63:0] rd_data;
    logic        key_avail;

    int n_checks = 0;
    int n_fail   = 0;

    kbd_input_fifo dut (
        .clk       (clk),
        .reset     (reset),
        .key_in    (key_in),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .key_avail (key_avail)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs are changed and outputs sampled 1ns after it.
    task automatic cyc(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rd(input logic [63:0] addr);
        rd_en   = 1'b1;
        rd_addr = addr;
        cyc();
        rd_en   = 1'b0;
        rd_addr = '0;
    endtask

    // Present a key for two edges so it is detected in either detection mode.
    task automatic key2(input logic [63:0] k);
        key_in = k;
        cyc(2);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        cyc(2);
        reset = 1'b1;
    endtask

    logic [63:0] exp_drain [8];

    initial begin
        key_in  = '0;
        rd_en   = 1'b0;
        rd_addr = '0;

        // Reset state
        do_reset();
        check("reset_rd_data", rd_data, 64'h0);
        check("reset_avail", 64'(key_avail), 64'h0);
        rd(STAT_A);
        check("reset_stat", rd_data, 64'h0);

        // Held key gives one entry
        key_in = 64'h41;
        cyc(10);
        check("held_avail", 64'(key_avail), 64'h1);
        key_in = '0;
        rd(DATA_A);
        check("held_pop", rd_data, 64'h41);
        check("held_avail_after", 64'(key_avail), 64'h0);
        rd(DATA_A);
        check("empty_pop", rd_data, 64'h0);

        // Unmapped address returns 0; rd_data holds without rd_en
        key2(64'h77);
        key_in = '0;
        cyc(2);
        rd(BAD_A);
        check("bad_addr", rd_data, 64'h0);
        rd(DATA_A);
        cyc(3);
        check("hold_rd_data", rd_data, 64'h77);

        // Nine keys into eight entries -> overflow
        for (int k = 0; k < 9; k++) key2(64'h41 + 64'(k));
        key_in = '0;
        cyc(2);
        rd(STAT_A);
        check("ovf_stat", rd_data, 64'h0803);
        for (int k = 0; k < 8; k++) begin
            rd(DATA_A);
            check("ovf_drain", rd_data, 64'h41 + 64'(k));
        end
        rd(STAT_A);
        check("ovf_stat_after", rd_data, 64'h0);

        // Full FIFO: push and pop on the same edge
        for (int k = 0; k < 8; k++) key2(64'h61 + 64'(k));
        key_in = '0;
        cyc(2);
        key_in = 64'h70;
`ifdef KBD_DEBOUNCE_EN
        cyc();
`endif
        rd(DATA_A);
        check("full_pp_pop", rd_data, 64'h61);
        key_in = '0;
        cyc(2);
        rd(STAT_A);
        check("full_pp_stat", rd_data, 64'h0801);
        for (int k = 0; k < 7; k++) exp_drain[k] = 64'h62 + 64'(k);
        exp_drain[7] = 64'h70;
        for (int k = 0; k < 8; k++) begin
            rd(DATA_A);
            check("full_pp_drain", rd_data, exp_drain[k]);
        end
        check("full_pp_empty", 64'(key_avail), 64'h0);

        // Release and re-press the same code -> two entries
        key2(64'h41);
        key2(64'h0);
        key2(64'h41);
        key2(64'h0);
        rd(STAT_A);
        check("repress_stat", rd_data, 64'h0201);
        rd(DATA_A);
        check("repress_pop1", rd_data, 64'h41);
        rd(DATA_A);
        check("repress_pop2", rd_data, 64'h41);

        // Reset discards queued keys
        key2(64'h31);
        key2(64'h32);
        key2(64'h33);
        key_in = '0;
        cyc(2);
        check("pre_reset_avail", 64'(key_avail), 64'h1);
        do_reset();
        check("post_reset_avail", 64'(key_avail), 64'h0);
        rd(STAT_A);
        check("post_reset_stat", rd_data, 64'h0);

        // Key held across reset release is pushed once
        key_in = 64'h44;
        do_reset();
`ifdef KBD_DEBOUNCE_EN
        cyc(2);
`else
        cyc(1);
`endif
        check("held_reset_avail", 64'(key_avail), 64'h1);
        cyc(3);
        rd(STAT_A);
        check("held_reset_stat", rd_data, 64'h0101);
        key_in = '0;
        rd(DATA_A);
        check("held_reset_pop", rd_data, 64'h44);

        // One-cycle pulse
        cyc(2);
        key_in = 64'h55;
        cyc();
        key_in = '0;
`ifdef KBD_DEBOUNCE_EN
        cyc(2);
        check("glitch_no_push", 64'(key_avail), 64'h0);
        key_in = 64'h55;
        cyc();
        check("deb_first_sample", 64'(key_avail), 64'h0);
        cyc();
        check("deb_second_sample", 64'(key_avail), 64'h1);
        cyc(2);
        key_in = '0;
        cyc(2);
        rd(STAT_A);
        check("deb_stat", rd_data, 64'h0101);
`else
        check("pulse_push", 64'(key_avail), 64'h1);
`endif
        rd(DATA_A);
        check("pulse_pop", rd_data, 64'h55);
        check("pulse_empty", 64'(key_avail), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/kbd_input_fifo.md
# kbd_input_fifo

Memory-mapped keyboard input stage between the external keystroke bus and the CPU core. It detects each new non-zero keystroke code on the 64-bit keystroke input, queues it in a small FIFO and serves it to the core through two read-only MMIO words (data and status). The core no longer polls the raw keystroke bus, so keystrokes arriving faster than the core consumes them are buffered rather than lost.

## Interface
- DEPTH, 8, FIFO entries; power of two, 2..256
- DATA_ADDR, 64'h100, address of the keystroke data word (read pops)
- STAT_ADDR, 64'h108, address of the status word (read has no pop side effect except overflow clear)
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-low reset; sampled on rising edge of clk
- key_in  in  64  raw keystroke code from keyboard source; 0 = no key
- rd_en  in  1  core read strobe, one cycle per access
- rd_addr  in  64  core read address, valid when rd_en=1
- rd_data  out  64  registered read data
- key_avail  out  1  FIFO non-empty, registered

## Operation
- Key detection: register prev_key <= key_in each cycle. Push when key_in != prev_key and key_in != 0. Holding a key produces one push; release to 0 then same code produces a second push; direct change A->B pushes B.
- FIFO: DEPTH entries of 64 bits, write/read pointers of log2(DEPTH) bits wrapping modulo DEPTH, count of log2(DEPTH)+1 bits.
- Read DATA_ADDR with rd_en: if non-empty, rd_data <= head entry, pop. If empty, rd_data <= 0, no pointer change.
- Read STAT_ADDR with rd_en: rd_data <= {47'b0, count[8:0] at bits 16:8, 6'b0, overflow at bit 1, key_avail at bit 0} (bits 7:2 zero); overflow cleared on the same edge.
- Read any other address with rd_en: rd_data <= 0, no side effect. rd_en=0: rd_data holds its last value.
- Full: push with count==DEPTH and no simultaneous pop -> keystroke dropped, overflow set (sticky).
- Push and pop on the same edge: both performed, count unchanged; legal when full (no overflow) and when count==1. Push when empty with simultaneous DATA read: read returns 0, key is stored.
- Overflow set and STAT read on the same edge: status reports the value before the edge, overflow ends at 1 (set wins).
- Reset: rd_data=0, key_avail=0, count=0, pointers=0, overflow=0, prev_key=0. Reset mid-operation discards all queued keys; a key held across reset release is pushed once on the first cycle after release (prev_key=0).

## Timing
- key_in change sampled at edge N -> entry written and count incremented at edge N; key_avail=1 visible after edge N.
- Read latency 1 cycle: rd_en/rd_addr at edge N -> rd_data valid after edge N, stable until next rd_en.
- key_avail and status count reflect state after the edge; a STAT read at edge N reports pre-edge count.
- No back-pressure; key_in can change every cycle.

## Configuration
- KBD_DEBOUNCE_EN defined: two-stage sampler; key_in accepted only after two consecutive identical samples. Tracking register last_stable updates to the stable value (including 0); push when stable value != last_stable and != 0. Detection latency +1 cycle; single-cycle glitches are never pushed.
- Undefined: detection as in Operation, zero extra latency.

## Test plan
- Reset 2 cycles, key_in=0 -> rd_data=0, key_avail=0, STAT read = 64'h0.
- key_in=64'h41 held 10 cycles, DATA read -> rd_data=64'h41; second DATA read -> 0; key_avail 1 then 0.
- Keys 0x41,0x42,...,0x49 (9 distinct, DEPTH=8), no reads -> STAT = 64'h0803; DATA reads return 0x41..0x48; STAT after = 64'h0000.
- FIFO full, key change and DATA read on same edge -> read returns oldest, new key stored, overflow stays 0, count stays 8.
- 0x41, 0, 0x41 sequence -> two entries of 0x41; reset asserted with 3 queued -> STAT=0 after reset.
- With KBD_DEBOUNCE_EN: one-cycle 0x55 pulse -> no push; 0x55 held 2 cycles -> one push, key_avail after second sample.
